// File: rtl/can_err_pkg.sv
// Shared types and constants for the CAN error-handling controller.
// Holds the confinement/FSM enums and the counter arithmetic limits.
package can_err_pkg;

  typedef enum logic [1:0] {
    ERR_ACTIVE  = 2'd0,
    ERR_PASSIVE = 2'd1,
    BUS_OFF     = 2'd2
  } node_state_t;

  typedef enum logic [2:0] {
    S_MONITOR,
    S_FLAG,
    S_WAIT_REC,
    S_DELIM,
    S_BUSOFF
  } fault_fsm_t;

  localparam int TEC_ERR_INC  = 8;
  localparam int REC_ERR_INC  = 1;
  localparam int REC_WAIT_INC = 8;
  localparam int PASSIVE_LIM  = 127;
  localparam int BUSOFF_LIM   = 256;
  localparam int REC_RESTORE  = 120;
  localparam int RECOVERY_RUN = 11;

  // Detector flags are active-low; any zero is an error event.
  function automatic logic any_error(input logic [4:0] flags_n);
    return ~&flags_n;
  endfunction

endpackage

// File: rtl/can_err_counters.sv
// TEC/REC registers with saturation, increment/decrement/restore arithmetic,
// and derivation of the fault-confinement state.
module can_err_counters
  import can_err_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        sp,
  input  logic        err_inc,
  input  logic        wait_inc,
  input  logic        ok_dec,
  input  logic        tx_role,
  input  logic        recover,
  output logic [8:0]  tec,
  output logic [7:0]  rec,
  output node_state_t node_state,
  output node_state_t node_nxt,
  output logic        busoff_nxt
);

  logic [8:0] tec_nxt;
  logic [7:0] rec_nxt;
  logic [9:0] tec_sum;
  logic [8:0] rec_sum;

  always_comb begin
    tec_nxt = tec;
    rec_nxt = rec;
    tec_sum = {1'b0, tec} + 10'(TEC_ERR_INC);
    rec_sum = {1'b0, rec} + (wait_inc ? 9'(REC_WAIT_INC) : 9'(REC_ERR_INC));
    if (sp) begin
      if (recover) begin
        tec_nxt = '0;
        rec_nxt = '0;
      end else if (err_inc || wait_inc) begin
        if (tx_role)
          tec_nxt = (tec_sum > 10'(BUSOFF_LIM)) ? 9'(BUSOFF_LIM) : tec_sum[8:0];
        else
          rec_nxt = rec_sum[8] ? 8'hff : rec_sum[7:0];
      end else if (ok_dec) begin
        if (tx_role) begin
          if (tec != '0)
            tec_nxt = tec - 9'd1;
        end else if (rec > 8'(PASSIVE_LIM)) begin
          rec_nxt = 8'(REC_RESTORE);
        end else if (rec != '0) begin
          rec_nxt = rec - 8'd1;
        end
      end
    end
  end

  // Bus-off is sticky: only a completed recovery releases it.
  always_comb begin
    node_nxt = node_state;
    if (sp) begin
      if (recover)
        node_nxt = ERR_ACTIVE;
      else if (node_state == BUS_OFF || tec_nxt >= 9'(BUSOFF_LIM))
        node_nxt = BUS_OFF;
      else if (tec_nxt > 9'(PASSIVE_LIM) || rec_nxt > 8'(PASSIVE_LIM))
        node_nxt = ERR_PASSIVE;
      else
        node_nxt = ERR_ACTIVE;
    end
  end

  assign busoff_nxt = (node_nxt == BUS_OFF);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tec        <= '0;
      rec        <= '0;
      node_state <= ERR_ACTIVE;
    end else begin
      tec        <= tec_nxt;
      rec        <= rec_nxt;
      node_state <= node_nxt;
    end
  end

endmodule

// File: rtl/can_fault_ctrl.sv
// CAN error-frame sequencer and bus-off recovery controller; the TEC/REC
// arithmetic and confinement state live in can_err_counters.
//
// state      | meaning
// S_MONITOR  | normal decoding, watching detector flags and FRAME_OK
// S_FLAG     | driving the error flag (dominant if active, recessive if passive)
// S_WAIT_REC | waiting for the first recessive bit after the flag
// S_DELIM    | counting recessive delimiter bits
// S_BUSOFF   | counting 11-bit recessive sequences until recovery
module can_fault_ctrl
  import can_err_pkg::*;
#(
  parameter int FLAG_LEN     = 6,
  parameter int DELIM_LEN    = 8,
  parameter int RECOVERY_SEQ = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX_BIT,
  input  logic       TX_ROLE,
  input  logic       STF_E,
  input  logic       CRC_E,
  input  logic       FRM_E,
  input  logic       ACK_E,
  input  logic       BIT_E,
  input  logic       FRAME_OK,
  output logic       TX_BIT,
  output logic       ERROR,
  output logic [1:0] NODE_STATE,
  output logic [8:0] TEC,
  output logic [7:0] REC
);

  localparam int MAX_LEN = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int SW      = $clog2(RECOVERY_SEQ + 1);
  localparam int RW      = $clog2(RECOVERY_RUN + 1);

  fault_fsm_t    state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_nxt;
  logic [2:0]    dom_cnt, dom_nxt;
  logic [RW-1:0] run_cnt, run_nxt;
  logic [SW-1:0] seq_cnt, seq_nxt;
  logic          tx_nxt, err_nxt;
  logic          detect, err_inc, wait_inc, ok_dec, recover;
  node_state_t   node_state, node_nxt;
  logic          busoff_nxt;

  assign detect   = any_error({STF_E, CRC_E, FRM_E, ACK_E, BIT_E});
  assign err_inc  = SP && ((state == S_MONITOR && detect) ||
                           (state == S_DELIM && !RX_BIT));
  assign wait_inc = SP && state == S_WAIT_REC && !RX_BIT && dom_cnt == 3'd7;
  assign ok_dec   = SP && state == S_MONITOR && !detect && FRAME_OK;
  assign recover  = SP && state == S_BUSOFF && RX_BIT &&
                    run_cnt == RW'(RECOVERY_RUN - 1) &&
                    seq_cnt == SW'(RECOVERY_SEQ - 1);

  can_err_counters u_counters (
    .clock      (clock),
    .reset      (reset),
    .sp         (SP),
    .err_inc    (err_inc),
    .wait_inc   (wait_inc),
    .ok_dec     (ok_dec),
    .tx_role    (TX_ROLE),
    .recover    (recover),
    .tec        (TEC),
    .rec        (REC),
    .node_state (node_state),
    .node_nxt   (node_nxt),
    .busoff_nxt (busoff_nxt)
  );

  assign NODE_STATE = node_state;

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    dom_nxt   = dom_cnt;
    run_nxt   = run_cnt;
    seq_nxt   = seq_cnt;
    tx_nxt    = TX_BIT;
    err_nxt   = ERROR;
    if (SP) begin
      case (state)
        S_MONITOR: begin
          tx_nxt  = 1'b1;
          err_nxt = 1'b1;
          if (detect) begin
            state_nxt = S_FLAG;
            bit_nxt   = '0;
            tx_nxt    = (node_nxt != ERR_ACTIVE);
            err_nxt   = 1'b0;
          end
        end
        S_FLAG: begin
          if (bit_cnt == CW'(FLAG_LEN - 1)) begin
            state_nxt = S_WAIT_REC;
            bit_nxt   = '0;
            dom_nxt   = '0;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_cnt + CW'(1);
            tx_nxt  = (node_state != ERR_ACTIVE);
          end
        end
        S_WAIT_REC: begin
          tx_nxt = 1'b1;
          if (RX_BIT) begin
            state_nxt = S_DELIM;
            bit_nxt   = CW'(1);
          end else begin
            dom_nxt = dom_cnt + 3'd1;
          end
        end
        S_DELIM: begin
          tx_nxt = 1'b1;
          if (!RX_BIT) begin
            state_nxt = S_FLAG;
            bit_nxt   = '0;
            tx_nxt    = (node_nxt != ERR_ACTIVE);
          end else if (bit_cnt == CW'(DELIM_LEN - 1)) begin
            state_nxt = S_MONITOR;
            bit_nxt   = '0;
            err_nxt   = 1'b1;
          end else begin
            bit_nxt = bit_cnt + CW'(1);
          end
        end
        S_BUSOFF: begin
          tx_nxt  = 1'b1;
          err_nxt = 1'b0;
          if (!RX_BIT) begin
            run_nxt = '0;
          end else if (run_cnt == RW'(RECOVERY_RUN - 1)) begin
            run_nxt = '0;
            if (seq_cnt == SW'(RECOVERY_SEQ - 1)) begin
              seq_nxt   = '0;
              state_nxt = S_MONITOR;
              err_nxt   = 1'b1;
            end else begin
              seq_nxt = seq_cnt + SW'(1);
            end
          end else begin
            run_nxt = run_cnt + RW'(1);
          end
        end
        default: state_nxt = S_MONITOR;
      endcase

      // Reaching the TEC limit preempts whatever the frame sequencer chose.
      if (state != S_BUSOFF && busoff_nxt) begin
        state_nxt = S_BUSOFF;
        tx_nxt    = 1'b1;
        err_nxt   = 1'b0;
        bit_nxt   = '0;
        dom_nxt   = '0;
        run_nxt   = '0;
        seq_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_MONITOR;
      bit_cnt <= '0;
      dom_cnt <= '0;
      run_cnt <= '0;
      seq_cnt <= '0;
      TX_BIT  <= 1'b1;
      ERROR   <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      dom_cnt <= dom_nxt;
      run_cnt <= run_nxt;
      seq_cnt <= seq_nxt;
      TX_BIT  <= tx_nxt;
      ERROR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_can_fault_ctrl.sv
// Self-checking bench for can_fault_ctrl: directed scenarios plus random
// traffic, compared every strobe against a behavioural error-handling model.
module tb_can_fault_ctrl;

  localparam int FLAG_LEN  = 6;
  localparam int DELIM_LEN = 8;
  localparam int RSEQ      = 128;

  localparam int PH_IDLE  = 0;
  localparam int PH_FLAG  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_DELIM = 3;
  localparam int PH_OFF   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       SP = 1'b0;
  logic       RX_BIT = 1'b1;
  logic       TX_ROLE = 1'b0;
  logic [4:0] flags_n = 5'h1f;
  logic       FRAME_OK = 1'b0;
  logic       TX_BIT, ERROR;
  logic [1:0] NODE_STATE;
  logic [8:0] TEC;
  logic [7:0] REC;

  can_fault_ctrl #(.FLAG_LEN(FLAG_LEN), .DELIM_LEN(DELIM_LEN), .RECOVERY_SEQ(RSEQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .SP         (SP),
    .RX_BIT     (RX_BIT),
    .TX_ROLE    (TX_ROLE),
    .STF_E      (flags_n[4]),
    .CRC_E      (flags_n[3]),
    .FRM_E      (flags_n[2]),
    .ACK_E      (flags_n[1]),
    .BIT_E      (flags_n[0]),
    .FRAME_OK   (FRAME_OK),
    .TX_BIT     (TX_BIT),
    .ERROR      (ERROR),
    .NODE_STATE (NODE_STATE),
    .TEC        (TEC),
    .REC        (REC)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: counters as integers, frame progress as bit counts.
  int   m_tec, m_rec, m_node, ph, fcnt, dcnt, dom, run, seq;
  logic m_tx, m_err;

  task automatic model_reset();
    m_tec = 0; m_rec = 0; m_node = 0; ph = PH_IDLE;
    fcnt = 0; dcnt = 0; dom = 0; run = 0; seq = 0;
    m_tx = 1'b1; m_err = 1'b1;
  endtask

  task automatic bump(input logic role, input bit is_event);
    if (role) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
    else      m_rec = (m_rec + (is_event ? 1 : 8) > 255) ? 255 : m_rec + (is_event ? 1 : 8);
  endtask

  task automatic model_sp(input logic rx, input logic role, input logic det, input logic ok);
    bit ev, wh, rcv;
    ev = 0; wh = 0; rcv = 0;
    case (ph)
      PH_IDLE: begin
        if (det) ev = 1;
        else if (ok) begin
          if (role) begin
            if (m_tec > 0) m_tec--;
          end else if (m_rec > 127) m_rec = 120;
          else if (m_rec > 0) m_rec--;
        end
      end
      PH_FLAG: begin
        fcnt++;
        if (fcnt == FLAG_LEN) begin ph = PH_WAIT; dom = 0; end
      end
      PH_WAIT: begin
        if (rx) begin ph = PH_DELIM; dcnt = 1; end
        else begin dom++; if (dom % 8 == 0) wh = 1; end
      end
      PH_DELIM: begin
        if (!rx) ev = 1;
        else begin dcnt++; if (dcnt == DELIM_LEN) ph = PH_IDLE; end
      end
      default: begin
        if (!rx) run = 0;
        else begin
          run++;
          if (run == 11) begin run = 0; seq++; if (seq == RSEQ) rcv = 1; end
        end
      end
    endcase
    if (ev) begin bump(role, 1); ph = PH_FLAG; fcnt = 0; end
    if (wh) bump(role, 0);
    if (rcv) begin
      m_tec = 0; m_rec = 0; m_node = 0; ph = PH_IDLE; seq = 0;
    end else if (m_node == 2 || m_tec >= 256) begin
      if (ph != PH_OFF) begin ph = PH_OFF; run = 0; seq = 0; end
      m_node = 2;
    end else begin
      m_node = (m_tec > 127 || m_rec > 127) ? 1 : 0;
    end
    m_tx  = (ph == PH_FLAG && m_node == 0) ? 1'b0 : 1'b1;
    m_err = (ph == PH_IDLE);
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_tx"},   32'(TX_BIT),     32'(m_tx));
    check_val({tag, "_err"},  32'(ERROR),      32'(m_err));
    check_val({tag, "_node"}, 32'(NODE_STATE), 32'(m_node));
    check_val({tag, "_tec"},  32'(TEC),        32'(m_tec));
    check_val({tag, "_rec"},  32'(REC),        32'(m_rec));
  endtask

  // One strobe: drive, let the edge happen, then leave a junk SP=0 cycle.
  task automatic do_sp(input string tag, input logic rx, input logic role,
                       input logic [4:0] flg, input logic ok);
    @(negedge clock);
    RX_BIT = rx; TX_ROLE = role; flags_n = flg; FRAME_OK = ok; SP = 1'b1;
    @(posedge clock);
    model_sp(rx, role, ~&flg, ok);
    @(negedge clock);
    SP = 1'b0;
    RX_BIT = 1'($urandom); TX_ROLE = 1'($urandom);
    flags_n = 5'($urandom); FRAME_OK = 1'($urandom);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; SP = 1'($urandom); flags_n = 5'($urandom);
    @(negedge clock);
    reset = 1'b1; SP = 1'b0;
    model_reset();
  endtask

  function automatic logic [4:0] one_err(input int idx);
    logic [4:0] v;
    v = 5'h1f;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic err_frame(input string tag, input logic role, input int idx, input int wait_dom);
    do_sp(tag, 1'b1, role, one_err(idx), 1'b0);
    repeat (FLAG_LEN) do_sp(tag, 1'b1, role, 5'h1f, 1'b0);
    repeat (wait_dom) do_sp(tag, 1'b0, role, 5'h1f, 1'b0);
    repeat (DELIM_LEN) do_sp(tag, 1'b1, role, 5'h1f, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_low, err_low, extra;
    logic [4:0] flg;
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs("reset");
    reset = 1'b1;

    // Receiver CRC error, recessive bus: 6 dominant flag bits, 14 strobes of ERROR.
    do_reset();
    tx_low = 0; err_low = 0;
    do_sp("t1", 1'b1, 1'b0, 5'b10111, 1'b0);
    if (TX_BIT == 1'b0) tx_low++;
    if (ERROR == 1'b0) err_low++;
    for (int i = 0; i < 19; i++) begin
      do_sp("t1", 1'b1, 1'b0, 5'h1f, 1'b0);
      if (TX_BIT == 1'b0) tx_low++;
      if (ERROR == 1'b0) err_low++;
    end
    check_val("t1_tx_low_strobes", 32'(tx_low), 32'd6);
    check_val("t1_err_low_strobes", 32'(err_low), 32'd14);
    check_val("t1_rec", 32'(REC), 32'd1);

    // Transmitter, 16 bit errors -> passive at TEC 128, next flag recessive.
    do_reset();
    for (int i = 0; i < 16; i++) err_frame("t2", 1'b1, 0, 0);
    check_val("t2_tec", 32'(TEC), 32'd128);
    check_val("t2_node", 32'(NODE_STATE), 32'd1);
    do_sp("t2", 1'b1, 1'b1, one_err(0), 1'b0);
    check_val("t2_passive_flag_tx", 32'(TX_BIT), 32'd1);
    check_val("t2_passive_flag_err", 32'(ERROR), 32'd0);

    // REC above the passive limit restored to 120 on a good frame.
    do_reset();
    err_frame("t3", 1'b0, 3, 128);
    err_frame("t3", 1'b0, 3, 0);
    check_val("t3_rec_pre", 32'(REC), 32'd130);
    do_sp("t3", 1'b1, 1'b0, 5'h1f, 1'b1);
    check_val("t3_rec_restore", 32'(REC), 32'd120);
    check_val("t3_node", 32'(NODE_STATE), 32'd0);

    // Bus-off entry at TEC 256, then recovery with an interrupted sequence.
    do_reset();
    err_frame("t4", 1'b1, 0, 240);
    check_val("t4_tec_pre", 32'(TEC), 32'd248);
    do_sp("t4", 1'b1, 1'b1, one_err(0), 1'b0);
    check_val("t4_tec_busoff", 32'(TEC), 32'd256);
    check_val("t4_node_busoff", 32'(NODE_STATE), 32'd2);
    for (int s = 0; s < RSEQ; s++)
      for (int b = 0; b < 11; b++) begin
        flg = 5'($urandom);
        if (s == 2 && b == 4) do_sp("t4", 1'b0, 1'b1, flg, 1'b0);
        do_sp("t4", 1'b1, 1'b1, flg, 1'b0);
      end
    check_val("t4_still_busoff", 32'(NODE_STATE), 32'd2);
    extra = 0;
    while (NODE_STATE == 2'd2 && extra < 50) begin
      do_sp("t4", 1'b1, 1'b1, 5'h1f, 1'b0);
      extra++;
    end
    check_val("t4_extra_bits", 32'(extra), 32'd4);
    check_val("t4_tec_rec", 32'(TEC), 32'd0);
    check_val("t4_rec", 32'(REC), 32'd0);
    check_val("t4_node_active", 32'(NODE_STATE), 32'd0);
    check_val("t4_err_idle", 32'(ERROR), 32'd1);

    // Error and FRAME_OK on the same strobe: error wins.
    do_reset();
    err_frame("t5", 1'b1, 0, 0);
    err_frame("t5", 1'b1, 0, 0);
    repeat (6) do_sp("t5", 1'b1, 1'b1, 5'h1f, 1'b1);
    check_val("t5_tec_pre", 32'(TEC), 32'd10);
    do_sp("t5", 1'b1, 1'b1, 5'b11011, 1'b1);
    check_val("t5_tec", 32'(TEC), 32'd18);
    check_val("t5_flag_err", 32'(ERROR), 32'd0);
    check_val("t5_flag_tx", 32'(TX_BIT), 32'd0);

    // Reset pulse at flag bit 3.
    do_reset();
    do_sp("t6", 1'b1, 1'b1, one_err(1), 1'b0);
    do_sp("t6", 1'b1, 1'b1, 5'h1f, 1'b0);
    do_sp("t6", 1'b1, 1'b1, 5'h1f, 1'b0);
    @(negedge clock);
    reset = 1'b0; SP = 1'b1; RX_BIT = 1'b0; flags_n = 5'h00;
    @(posedge clock);
    #1;
    model_reset();
    check_outputs("t6_reset");
    @(negedge clock);
    reset = 1'b1; SP = 1'b0;
    do_sp("t6_post", 1'b1, 1'b0, 5'h1f, 1'b1);
    do_sp("t6_post", 1'b1, 1'b0, one_err(4), 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic rx, role, ok;
      rx   = ($urandom_range(0, 99) < 85);
      role = 1'($urandom);
      ok   = ($urandom_range(0, 5) == 0);
      flg  = ($urandom_range(0, 11) == 0) ? one_err(int'($urandom_range(0, 4))) : 5'h1f;
      do_sp("rand", rx, role, flg, ok);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/can_fault_ctrl.md
# can_fault_ctrl

CAN error-handling controller sitting between the decoder's error detectors and the bit transmitter. It collapses the active-low detector flags into error events and sequences the error frame: flag, recessive wait, delimiter. It maintains the transmit/receive error counters (TEC/REC) and the fault-confinement state: error-active, error-passive, bus-off. It also runs bus-off recovery, then hands the bus back to normal decoding.

## Interface
- `FLAG_LEN`, 6, error flag length in bits
- `DELIM_LEN`, 8, error delimiter length in bits
- `RECOVERY_SEQ`, 128, count of 11-recessive-bit sequences needed to leave bus-off
- `clock` input 1: single clock for all state
- `reset` input 1: synchronous, active-low reset
- `SP` input 1: sample-point strobe, one `clock` cycle wide; all protocol state advances only on cycles with `SP`=1
- `RX_BIT` input 1: bus level sampled at this `SP` (1 = recessive)
- `TX_ROLE` input 1: 1 = this node is transmitter of the current frame
- `STF_E`, `CRC_E`, `FRM_E`, `ACK_E`, `BIT_E` input 1 each: detector flags, active-low
- `FRAME_OK` input 1: active-high, one `SP` wide, frame completed without error
- `TX_BIT` output 1: level to drive on the bus (1 = recessive)
- `ERROR` output 1: active-low, 0 while an error frame is in progress
- `NODE_STATE` output 2: 0 = ERR_ACTIVE, 1 = ERR_PASSIVE, 2 = BUS_OFF
- `TEC` output 9: transmit error count
- `REC` output 8: receive error count

## Operation
- Error event: sampled on `SP` in state MONITOR when any of `STF_E`/`CRC_E`/`FRM_E`/`ACK_E`/`BIT_E` = 0.
- FSM states: MONITOR, FLAG, WAIT_REC, DELIM, BUSOFF.
- **MONITOR**
  - `TX_BIT`=1, `ERROR`=1.
  - On an error event: apply the counter increment and go to FLAG with the bit counter cleared.
  - On `FRAME_OK` with no error: apply the counter decrement.
- **FLAG**: `FLAG_LEN` bits.
  - `TX_BIT`=0 when ERR_ACTIVE; `TX_BIT`=1 when ERR_PASSIVE.
  - After the last bit, go to WAIT_REC.
- **WAIT_REC**: `TX_BIT`=1.
  - On the first `RX_BIT`=1, go to DELIM; that bit counts as delimiter bit 1.
  - Every 8 consecutive dominant bits here apply a further increment: TEC+8 if `TX_ROLE`, else REC+8.
- **DELIM**: `TX_BIT`=1 for `DELIM_LEN` total recessive bits, then go to MONITOR.
  - A dominant `RX_BIT` in DELIM is a new error event: apply the increment and restart FLAG.
- **Increment on error event**: `TX_ROLE`=1 → TEC += 8; else REC += 1.
- **Decrement on `FRAME_OK`**:
  - `TX_ROLE`=1 → TEC -= 1 if TEC > 0.
  - `TX_ROLE`=0:
    - REC in 1..127 → REC -= 1.
    - REC > 127 → REC = 120.
    - REC = 0 → no change.
- **Counter bounds**: REC saturates at 255. TEC ≥ 256 forces BUS_OFF immediately, from any FSM state, and TEC holds at 256.
- **Confinement state** is recomputed every `SP` from the counters:
  - TEC > 127 or REC > 127 → ERR_PASSIVE.
  - Otherwise → ERR_ACTIVE.
  - BUS_OFF is sticky until recovery completes.
- **BUSOFF**
  - `TX_BIT`=1, `ERROR`=0, detector flags ignored.
  - A run counter counts consecutive recessive bits and is cleared by any dominant bit.
  - At a run of 11, increment the sequence counter and clear the run.
  - At `RECOVERY_SEQ` sequences: TEC=0, REC=0, ERR_ACTIVE, MONITOR.
- **Priorities**
  - Error event and `FRAME_OK` on the same `SP`: error wins, no decrement.
  - Detector flags outside MONITOR are ignored; DELIM uses the `RX_BIT` rule only.

## Timing
- All outputs are registered and reset together.
- **Reset values**: `TX_BIT`=1, `ERROR`=1, `NODE_STATE`=0, `TEC`=0, `REC`=0; FSM = MONITOR; all internal counters = 0.
- **Latency**
  - Error sampled on `SP` n → `TX_BIT`, `ERROR`, `TEC`/`REC` updated on the `clock` edge at `SP` n.
  - They are therefore valid before `SP` n+1, which is flag bit 1.
- Cycles with `SP`=0 change nothing.
- An error frame occupies `FLAG_LEN` + (wait bits) + `DELIM_LEN` `SP` strobes.
  - Minimum is 14 strobes with the defaults.
  - `ERROR` returns to 1 on the edge that enters MONITOR.
- Reset asserted mid-frame or mid-recovery: on the next `clock` edge the block returns to the reset values, regardless of `SP`.

## Structure
- Shared package `can_err_pkg` holds:
  - the `node_state_t` enum (ERR_ACTIVE, ERR_PASSIVE, BUS_OFF) and the `fault_fsm_t` enum;
  - the constants TEC_ERR_INC=8, REC_ERR_INC=1, PASSIVE_LIM=127, BUSOFF_LIM=256, REC_RESTORE=120, RECOVERY_RUN=11.
- One sub-module, `can_err_counters`, holds:
  - the TEC/REC registers with saturation;
  - the increment/decrement/restore arithmetic;
  - confinement-state derivation.
- The top-level holds the FSM and the flag, delimiter and recovery counters.

## Test plan
- Receiver, `CRC_E`=0 on one `SP`, bus recessive afterwards:
  - `TX_BIT`=0 for 6 strobes, then 1;
  - REC=1;
  - `ERROR` low for exactly 14 strobes.
- Transmitter, 16 consecutive `BIT_E` errors each followed by a clean error frame:
  - TEC reaches 128 and `NODE_STATE`=1 after the 16th error;
  - next flag is passive (`TX_BIT` stays 1).
- REC=130, receiver, `FRAME_OK` → REC=120 and `NODE_STATE`=0.
- TEC=248, transmitter, one error → TEC=256 and `NODE_STATE`=2.
  - Then feed 128×11 recessive bits with one dominant bit injected at bit 5 of sequence 3.
  - Required: recovery completes after 128 full sequences; TEC=REC=0, `NODE_STATE`=0.
- Same `SP` with `FRM_E`=0 and `FRAME_OK`=1, transmitter at TEC=10 → TEC=18, FLAG entered.
- Error frame in progress, `reset`=0 for one cycle at flag bit 3 → next edge: `TX_BIT`=1, `ERROR`=1, FSM = MONITOR, counters 0.
